// File: rtl/exe_stage.sv
// Execute stage: one-hot ALU, MTHI/MTLO, signed MULT, and the EXE->MEM bus.
// Define EXE_FAST_MULT_EN for a single-cycle multiply; otherwise a 33-cycle shift-add FSM is used.
module exe_stage #(
  parameter int ID_EXE_BUS_WIDTH  = 167,
  parameter int EXE_MEM_BUS_WIDTH = 154
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         EXE_valid,
  input  logic [ID_EXE_BUS_WIDTH-1:0]  ID_EXE_bus_r,
  input  logic                         MEM_allowin,
  output logic                         EXE_over,
  output logic [EXE_MEM_BUS_WIDTH-1:0] EXE_MEM_bus,
  output logic [4:0]                   EXE_wdest,
  output logic [31:0]                  EXE_pc
);

  logic        multiply, mthi, mtlo;
  logic [11:0] alu_control;
  logic [31:0] op1, op2;
  logic [3:0]  mem_control;
  logic [31:0] store_data;
  logic        mfhi, mflo, mtc0, mfc0;
  logic [7:0]  cp0r_addr;
  logic        syscall, eret, rf_wen;
  logic [4:0]  rf_wdest;
  logic [31:0] pc;

  assign {multiply, mthi, mtlo, alu_control, op1, op2, mem_control, store_data,
          mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, eret, rf_wen, rf_wdest, pc} = ID_EXE_bus_r;

  logic [63:0] product_s;
  logic        mult_done_s;

`ifdef EXE_FAST_MULT_EN
  assign product_s   = $signed({{32{op1[31]}}, op1}) * $signed({{32{op2[31]}}, op2});
  assign mult_done_s = 1'b1;
`else
  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_DONE} state_e;

  state_e      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [63:0] acc_q, acc_d;
  logic [32:0] mcand_q, mcand_d;
  logic [32:0] mplr_q, mplr_d;
  logic        sign_q, sign_d;

  // 33-bit magnitude so that 0x80000000 stays exact
  function automatic logic [32:0] abs33(input logic [31:0] v);
    abs33 = v[31] ? (33'd0 - {1'b1, v}) : {1'b0, v};
  endfunction

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= S_IDLE;
      cnt_q   <= 6'd0;
      acc_q   <= 64'd0;
      mcand_q <= 33'd0;
      mplr_q  <= 33'd0;
      sign_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      sign_q  <= sign_d;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    sign_d  = sign_q;
    case (state_q)
      S_IDLE: begin
        if (EXE_valid && multiply) begin
          mcand_d = abs33(op1);
          mplr_d  = abs33(op2);
          sign_d  = op1[31] ^ op2[31];
          acc_d   = 64'd0;
          cnt_d   = 6'd0;
          state_d = S_BUSY;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_BUSY: begin
        // multiplier shifts right; its LSB selects the shifted multiplicand
        if (mplr_q[0]) begin
          acc_d = acc_q + ({31'd0, mcand_q} << cnt_q);
        end else begin
          acc_d = acc_q;
        end
        mplr_d = mplr_q >> 1;
        if (cnt_q == 6'd31) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_DONE: begin
        if (!EXE_valid) begin
          state_d = S_IDLE;
        end else if (EXE_over && MEM_allowin) begin
          state_d = S_IDLE;
        end else begin
          state_d = S_DONE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  assign product_s   = sign_q ? (64'd0 - acc_q) : acc_q;
  assign mult_done_s = (state_q == S_DONE);
`endif

  logic [31:0] alu_res_s;
  logic [4:0]  sa_s;
  assign sa_s = op1[4:0];

  always_comb begin
    alu_res_s = 32'd0;
    if      (alu_control[11]) alu_res_s = op1 + op2;
    else if (alu_control[10]) alu_res_s = op1 - op2;
    else if (alu_control[9])  alu_res_s = {31'd0, ($signed(op1) < $signed(op2))};
    else if (alu_control[8])  alu_res_s = {31'd0, (op1 < op2)};
    else if (alu_control[7])  alu_res_s = op1 & op2;
    else if (alu_control[6])  alu_res_s = ~(op1 | op2);
    else if (alu_control[5])  alu_res_s = op1 | op2;
    else if (alu_control[4])  alu_res_s = op1 ^ op2;
    else if (alu_control[3])  alu_res_s = op2 << sa_s;
    else if (alu_control[2])  alu_res_s = op2 >> sa_s;
    else if (alu_control[1])  alu_res_s = $unsigned($signed(op2) >>> sa_s);
    else if (alu_control[0])  alu_res_s = {op2[15:0], 16'd0};
    else                      alu_res_s = 32'd0;
  end

  logic [31:0] exe_result_s, lo_result_s;
  logic        hi_write_s, lo_write_s;

  always_comb begin
    exe_result_s = alu_res_s;
    lo_result_s  = 32'd0;
    hi_write_s   = mthi;
    lo_write_s   = mtlo;
    if (multiply) begin
      exe_result_s = product_s[63:32];
      lo_result_s  = product_s[31:0];
      hi_write_s   = 1'b1;
      lo_write_s   = 1'b1;
    end else if (mthi) begin
      exe_result_s = op1;
    end else if (mtlo) begin
      exe_result_s = 32'd0;
      lo_result_s  = op1;
    end else begin
      exe_result_s = alu_res_s;
    end
  end

  assign EXE_over    = EXE_valid & ~reset & (~multiply | mult_done_s);
  assign EXE_MEM_bus = {mem_control, store_data, exe_result_s, lo_result_s, hi_write_s, lo_write_s,
                        mfhi, mflo, mtc0, mfc0, cp0r_addr, syscall, eret, rf_wen, rf_wdest, pc};
  assign EXE_wdest   = EXE_valid ? rf_wdest : 5'd0;
  assign EXE_pc      = pc;

endmodule

// File: tb/tb_exe_stage.sv
// Scoreboard bench for exe_stage: stimulus pushes expected EXE->MEM bus and due cycle,
// a negedge monitor compares every cycle EXE_over is high and pops on MEM_allowin.
module tb_exe_stage;

  logic         clk = 1'b0;
  logic         reset;
  logic         EXE_valid;
  logic [166:0] ID_EXE_bus_r;
  logic         MEM_allowin;
  logic         EXE_over;
  logic [153:0] EXE_MEM_bus;
  logic [4:0]   EXE_wdest;
  logic [31:0]  EXE_pc;

  exe_stage dut (
    .clk         (clk),
    .reset       (reset),
    .EXE_valid   (EXE_valid),
    .ID_EXE_bus_r(ID_EXE_bus_r),
    .MEM_allowin (MEM_allowin),
    .EXE_over    (EXE_over),
    .EXE_MEM_bus (EXE_MEM_bus),
    .EXE_wdest   (EXE_wdest),
    .EXE_pc      (EXE_pc)
  );

  always #5 clk = ~clk;

`ifdef EXE_FAST_MULT_EN
  localparam int MUL_LAT = 0;
`else
  localparam int MUL_LAT = 33;
`endif

  typedef struct {
    logic [153:0] bus;
    logic [4:0]   wd;
    int           due;
    string        name;
  } exp_t;

  exp_t q[$];
  int   cyc = 0;
  int   vectors = 0;
  int   fails = 0;
  bit   first_seen = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [153:0] act, input logic [153:0] req);
    vectors++;
    if (act !== req) begin
      fails++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, req, cyc);
    end
  endtask

  function automatic logic [153:0] exp_bus(input logic [31:0] exe, input logic [31:0] lo,
                                           input logic hw, input logic lw,
                                           input logic [4:0] wd, input logic [31:0] pc);
    return {4'h5, pc ^ 32'h5A5A0000, exe, lo, hw, lw, 4'b0101, 8'hA5, 3'b011, wd, pc};
  endfunction

  // monitor: compare head of scoreboard whenever EXE_over is high
  always @(negedge clk) begin
    if (EXE_over) begin
      if (q.size() == 0) begin
        vectors++;
        fails++;
        $display("FAIL unexpected_over: got EXE_over=1 expected 0 (cycle %0d)", cyc);
      end else begin
        if (!first_seen) begin
          chk({q[0].name, "_latency"}, 154'(cyc), 154'(q[0].due));
          first_seen = 1'b1;
        end
        chk({q[0].name, "_bus"}, EXE_MEM_bus, q[0].bus);
        chk({q[0].name, "_wdest"}, 154'(EXE_wdest), 154'(q[0].wd));
        if (MEM_allowin) begin
          void'(q.pop_front());
          first_seen = 1'b0;
        end
      end
    end
  end

  task automatic set_in(input logic mul, input logic mth, input logic mtl, input logic [11:0] ctl,
                        input logic [31:0] a, input logic [31:0] b, input logic [4:0] wd,
                        input logic [31:0] pc);
    EXE_valid    = 1'b1;
    ID_EXE_bus_r = {mul, mth, mtl, ctl, a, b, 4'h5, pc ^ 32'h5A5A0000,
                    4'b0101, 8'hA5, 3'b011, wd, pc};
  endtask

  task automatic issue(input string name, input logic mul, input logic mth, input logic mtl,
                       input logic [11:0] ctl, input logic [31:0] a, input logic [31:0] b,
                       input logic [4:0] wd, input logic [31:0] exe, input logic [31:0] lo,
                       input logic hw, input logic lw);
    exp_t e;
    logic [31:0] pc;
    pc = 32'h0000_1000 + 32'(cyc * 4);
    set_in(mul, mth, mtl, ctl, a, b, wd, pc);
    e.bus  = exp_bus(exe, lo, hw, lw, wd, pc);
    e.wd   = wd;
    e.due  = cyc + (mul ? MUL_LAT : 0);
    e.name = name;
    q.push_back(e);
  endtask

  // wait for handshake, bounded, then step to the next drive point
  task automatic finish_vec(input string name);
    bit done;
    done = 1'b0;
    for (int i = 0; i < 100 && !done; i++) begin
      @(negedge clk);
      if (EXE_over && MEM_allowin) done = 1'b1;
    end
    if (!done) begin
      vectors++;
      fails++;
      $display("FAIL %s_timeout: got no handshake expected one within 100 cycles", name);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic alu(input string name, input logic [11:0] ctl, input logic [31:0] a,
                     input logic [31:0] b, input logic [31:0] exe);
    issue(name, 1'b0, 1'b0, 1'b0, ctl, a, b, 5'd3, exe, 32'd0, 1'b0, 1'b0);
    finish_vec(name);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b1;
    MEM_allowin = 1'b1;
    set_in(1'b0, 1'b0, 1'b0, 12'h800, 32'd1, 32'd2, 5'd9, 32'hBFC0_0000);
    repeat (2) @(posedge clk);
    #1;
    @(negedge clk);
    chk("reset_over", 154'(EXE_over), 154'd0);
    chk("reset_wdest", 154'(EXE_wdest), 154'd9);
    chk("reset_pc", 154'(EXE_pc), 154'h0BFC0_0000);
    @(posedge clk);
    #1;
    reset = 1'b0;
    EXE_valid = 1'b0;
    @(negedge clk);
    chk("idle_wdest", 154'(EXE_wdest), 154'd0);
    chk("idle_over", 154'(EXE_over), 154'd0);
    @(posedge clk);
    #1;

    alu("add_wrap", 12'h800, 32'hFFFF_FFFF, 32'h0000_0001, 32'h0000_0000);
    alu("sub",      12'h400, 32'd5,         32'd7,         32'hFFFF_FFFE);
    alu("slt",      12'h200, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0001);
    alu("sltu",     12'h100, 32'hFFFF_FFFE, 32'h0000_0001, 32'h0000_0000);
    alu("and",      12'h080, 32'hF0F0_F0F0, 32'hFF00_FF00, 32'hF000_F000);
    alu("nor",      12'h040, 32'hF0F0_F0F0, 32'h0F0F_0000, 32'h0000_0F0F);
    alu("or",       12'h020, 32'h00FF_0000, 32'h0000_00FF, 32'h00FF_00FF);
    alu("xor",      12'h010, 32'hAAAA_AAAA, 32'hFFFF_FFFF, 32'h5555_5555);
    alu("sll",      12'h008, 32'h0000_0024, 32'h0000_0003, 32'h0000_0030);
    alu("srl",      12'h004, 32'h0000_0004, 32'h8000_0000, 32'h0800_0000);
    alu("sra",      12'h002, 32'h0000_0004, 32'h8000_0000, 32'hF800_0000);
    alu("lui",      12'h001, 32'h0000_0000, 32'h0000_1234, 32'h1234_0000);
    alu("no_op",    12'h000, 32'h1234_5678, 32'h9ABC_DEF0, 32'h0000_0000);

    issue("mthi", 1'b0, 1'b1, 1'b0, 12'h800, 32'hDEAD_BEEF, 32'd1, 5'd4,
          32'hDEAD_BEEF, 32'd0, 1'b1, 1'b0);
    finish_vec("mthi");
    issue("mtlo", 1'b0, 1'b0, 1'b1, 12'h000, 32'hCAFE_BABE, 32'd1, 5'd5,
          32'd0, 32'hCAFE_BABE, 1'b0, 1'b1);
    finish_vec("mtlo");

    issue("mult_neg", 1'b1, 1'b0, 1'b0, 12'h000, 32'hFFFF_FFFD, 32'd5, 5'd6,
          32'hFFFF_FFFF, 32'hFFFF_FFF1, 1'b1, 1'b1);
    finish_vec("mult_neg");
    issue("mult_min", 1'b1, 1'b0, 1'b0, 12'h000, 32'h8000_0000, 32'h8000_0000, 5'd7,
          32'h4000_0000, 32'h0000_0000, 1'b1, 1'b1);
    finish_vec("mult_min");
    issue("mult_max_min", 1'b1, 1'b0, 1'b0, 12'h000, 32'h7FFF_FFFF, 32'h8000_0000, 5'd8,
          32'hC000_0000, 32'h8000_0000, 1'b1, 1'b1);
    finish_vec("mult_max_min");

    // result held five cycles with MEM_allowin low, then a back-to-back MULT
    MEM_allowin = 1'b0;
    issue("mult_hold", 1'b1, 1'b0, 1'b0, 12'h000, 32'h1234_5678, 32'h0000_0010, 5'd10,
          32'h0000_0001, 32'h2345_6780, 1'b1, 1'b1);
    repeat (MUL_LAT + 5) @(posedge clk);
    #1;
    MEM_allowin = 1'b1;
    finish_vec("mult_hold");
    issue("mult_b2b", 1'b1, 1'b0, 1'b0, 12'h000, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd11,
          32'h0000_0000, 32'h0000_0001, 1'b1, 1'b1);
    finish_vec("mult_b2b");

    // reset in the middle of a MULT, then a fresh MULT
    set_in(1'b1, 1'b0, 1'b0, 12'h000, 32'd123, 32'd45, 5'd12, 32'h0000_2000);
`ifndef EXE_FAST_MULT_EN
    repeat (10) @(posedge clk);
    #1;
`endif
    reset = 1'b1;
    @(negedge clk);
    chk("midreset_over", 154'(EXE_over), 154'd0);
    @(posedge clk);
    #1;
    reset = 1'b0;
    issue("mult_after_reset", 1'b1, 1'b0, 1'b0, 12'h000, 32'd7, 32'd6, 5'd13,
          32'd0, 32'd42, 1'b1, 1'b1);
    finish_vec("mult_after_reset");

    EXE_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("scoreboard_empty", 154'(q.size()), 154'd0);
    $display("== %0d vectors applied, %0d miscompares ==", vectors, fails);
    $finish;
  end

endmodule
